spi_master_engine: RTL and testbench

Mode-0 (CPOL=0, CPHA=0), MSB-first SPI master engine. It accepts a parallel word over a valid/ready handshake, generates `cs_n` and `sclk`, serialises the word on `mosi`, and deserialises `miso` into a received word reported with a one-cycle strobe. It sits directly upstream of the pad tri-state buffer: `mosi`/`mosi_oe` feed that buffer's `in`/`oe`, and the engine drives it only while a frame is active.

---
 rtl/spi_master_engine.sv | 130 +++++++++++++
 tb/tb_spi_master_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_engine.sv
// Mode-0, MSB-first SPI master: one word per valid/ready handshake, received
// word reported with a one-cycle strobe. Drives mosi/mosi_oe only inside a frame.
module spi_master_engine #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic             busy,
   output logic             sclk,
   output logic             mosi,
   output logic             mosi_oe,
   input  logic             miso,
   output logic             cs_n
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BitW = $clog2(WIDTH + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [BitW-1:0] BitLast = BitW'(WIDTH);

   typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

   state_e           state_q, state_d;
   logic [DivW-1:0]  div_q, div_d;
   logic [BitW-1:0]  bit_q, bit_d;
   logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             sclk_q, sclk_d;
   logic             rx_valid_q, rx_valid_d;
   logic             div_wrap;

   assign div_wrap = (div_q == DivLast);

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      sclk_d     = sclk_q;
      rx_valid_d = 1'b0;

      if (state_q != StIdle) begin
         div_d = div_wrap ? '0 : div_q + DivW'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (tx_valid) begin
               state_d = StSetup;
               tx_sr_d = tx_data;
               rx_sr_d = '0;
               div_d   = '0;
               bit_d   = '0;
               sclk_d  = 1'b0;
            end
         end
         // The SETUP->XFER edge is also the first sclk rising edge.
         StSetup: begin
            if (div_wrap) begin
               state_d = StXfer;
               sclk_d  = 1'b1;
               rx_sr_d = {rx_sr_q[WIDTH-2:0], miso};
               bit_d   = bit_q + BitW'(1);
            end
         end
         StXfer: begin
            if (div_wrap) begin
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  rx_sr_d = {rx_sr_q[WIDTH-2:0], miso};
                  bit_d   = bit_q + BitW'(1);
               end else if (bit_q == BitLast) begin
                  state_d = StHold;
               end else begin
                  tx_sr_d = tx_sr_q << 1;
               end
            end
         end
         StHold: begin
            if (div_wrap) begin
               state_d    = StIdle;
               rx_data_d  = rx_sr_q;
               rx_valid_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         div_q      <= '0;
         bit_q      <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         sclk_q     <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         sclk_q     <= sclk_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign tx_ready = (state_q == StIdle);
   assign busy     = ~tx_ready;
   assign cs_n     = tx_ready;
   assign mosi_oe  = busy;
   assign mosi     = busy & tx_sr_q[WIDTH-1];
   assign sclk     = sclk_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench: WIDTH=8 engines at CLK_DIV=4 and CLK_DIV=1 with a mode-0 slave model.
module tb_spi_master_engine;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // CLK_DIV=4 instance
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, rx_valid, busy, sclk, mosi, mosi_oe, cs_n;
   logic [7:0] rx_data;
   logic       miso = 1'b0;

   // CLK_DIV=1 instance
   logic       tx_valid1 = 1'b0;
   logic [7:0] tx_data1 = 8'h00;
   logic       tx_ready1, rx_valid1, busy1, sclk1, mosi1, mosi_oe1, cs_n1;
   logic [7:0] rx_data1;
   logic       miso1 = 1'b1;

   spi_master_engine #(.WIDTH(8), .CLK_DIV(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sclk(sclk), .mosi(mosi),
      .mosi_oe(mosi_oe), .miso(miso), .cs_n(cs_n)
   );

   spi_master_engine #(.WIDTH(8), .CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
      .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1), .sclk(sclk1), .mosi(mosi1),
      .mosi_oe(mosi_oe1), .miso(miso1), .cs_n(cs_n1)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor + slave model for the CLK_DIV=4 instance, sampled on the falling clk edge.
   logic [7:0]  sl_word = 8'h00;
   logic [7:0]  sl_sr = 8'h00;
   logic        busy_p = 1'b0, cs_p = 1'b1, sclk_p = 1'b0;
   int unsigned n = 0, acc_cnt = 0, acc_n = 0, rxv_cnt = 0, rxv_n = 0, rise_cnt = 0;
   int unsigned cs_run = 0, cs_gap = 0;
   logic [7:0]  mosi_log = 8'h00, frame_mosi = 8'h00;

   always @(negedge clk) begin
      n      <= n + 1;
      busy_p <= busy;
      cs_p   <= cs_n;
      sclk_p <= sclk;
      if (busy && !busy_p) begin
         acc_cnt <= acc_cnt + 1;
         acc_n   <= n;
      end
      if (rx_valid) begin
         rxv_cnt    <= rxv_cnt + 1;
         rxv_n      <= n;
         frame_mosi <= mosi_log;
      end
      if (sclk && !sclk_p) begin
         rise_cnt <= rise_cnt + 1;
         mosi_log <= {mosi_log[6:0], mosi};
      end
      if (cs_n) cs_run <= cs_run + 1;
      else cs_run <= 0;
      if (!cs_n && cs_p) cs_gap <= cs_run;
      // Slave: MSB out before the first rising edge, next bit after each falling edge.
      if (!cs_n && cs_p) begin
         miso  <= sl_word[7];
         sl_sr <= sl_word << 1;
      end else if (!sclk && sclk_p) begin
         miso  <= sl_sr[7];
         sl_sr <= sl_sr << 1;
      end
   end

   // Monitor for the CLK_DIV=1 instance.
   logic        busy1_p = 1'b0, sclk1_p = 1'b0;
   int unsigned acc1_n = 0, rxv1_cnt = 0, rxv1_n = 0, rise1_cnt = 0, rise1_n = 0, rise1_gap = 0;
   logic [7:0]  mosi1_log = 8'h00, frame_mosi1 = 8'h00;

   always @(negedge clk) begin
      busy1_p <= busy1;
      sclk1_p <= sclk1;
      if (busy1 && !busy1_p) acc1_n <= n;
      if (rx_valid1) begin
         rxv1_cnt    <= rxv1_cnt + 1;
         rxv1_n      <= n;
         frame_mosi1 <= mosi1_log;
      end
      if (sclk1 && !sclk1_p) begin
         rise1_cnt <= rise1_cnt + 1;
         rise1_n   <= n;
         rise1_gap <= n - rise1_n;
         mosi1_log <= {mosi1_log[6:0], mosi1};
      end
   end

   task automatic send0(input logic [7:0] d);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_rxv0(input int unsigned target, input string tag);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (rxv_cnt >= target) break;
      end
      check_eq(tag, rxv_cnt, target);
   endtask

   task automatic wait_acc0(input int unsigned target, input string tag);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (acc_cnt >= target) break;
      end
      check_eq(tag, acc_cnt, target);
   endtask

   task automatic wait_rise0(input int unsigned target, input string tag);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (rise_cnt >= target) break;
      end
      check_eq(tag, rise_cnt, target);
   endtask

   int unsigned r0, a0, s0, v1, a2;

   initial begin
      // Reset values
      #12;
      check_eq("rst_cs_n", cs_n, 1);
      check_eq("rst_sclk", sclk, 0);
      check_eq("rst_mosi", mosi, 0);
      check_eq("rst_mosi_oe", mosi_oe, 0);
      check_eq("rst_tx_ready", tx_ready, 1);
      check_eq("rst_rx_valid", rx_valid, 0);
      check_eq("rst_rx_data", rx_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_tx_ready1", tx_ready1, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_tx_ready", tx_ready, 1);

      // 0xA5 out, slave returns 0x3C
      r0 = rxv_cnt; s0 = rise_cnt;
      sl_word = 8'h3C;
      send0(8'hA5);
      wait_rxv0(r0 + 1, "a5_done");
      check_eq("a5_mosi_bits", frame_mosi, 8'hA5);
      check_eq("a5_rx_data", rx_data, 8'h3C);
      check_eq("a5_sclk_pulses", rise_cnt - s0, 8);
      check_eq("a5_latency", rxv_n - acc_n, 68);
      #1;
      check_eq("a5_rx_valid_drop", rx_valid, 0);
      check_eq("a5_cs_n_end", cs_n, 1);
      check_eq("a5_mosi_oe_end", mosi_oe, 0);
      @(negedge clk);
      @(posedge clk);
      check_eq("a5_one_strobe", rxv_cnt - r0, 1);

      // Back-to-back: 0x01 then 0xFF with tx_valid held high
      r0 = rxv_cnt; a0 = acc_cnt;
      sl_word = 8'hC3;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h01;
      wait_acc0(a0 + 1, "b2b_acc1");
      @(negedge clk);
      tx_data = 8'hFF;
      wait_rxv0(r0 + 1, "b2b_rxv1");
      v1 = rxv_n;
      check_eq("b2b_mosi1", frame_mosi, 8'h01);
      check_eq("b2b_rx1", rx_data, 8'hC3);
      wait_acc0(a0 + 2, "b2b_acc2");
      a2 = acc_n;
      @(negedge clk);
      tx_valid = 1'b0;
      check_eq("b2b_acc_in_rxv_cycle", a2 - v1, 1);
      check_eq("b2b_cs_gap", cs_gap, 1);
      wait_rxv0(r0 + 2, "b2b_rxv2");
      check_eq("b2b_rxv_spacing", rxv_n - v1, 69);
      check_eq("b2b_mosi2", frame_mosi, 8'hFF);
      check_eq("b2b_rx2", rx_data, 8'hC3);

      // tx_valid/tx_data activity mid-frame is ignored
      r0 = rxv_cnt; a0 = acc_cnt; s0 = rise_cnt;
      sl_word = 8'h81;
      send0(8'h12);
      wait_rise0(s0 + 3, "ign_rise3");
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'hEE;
      wait_rxv0(r0 + 1, "ign_done");
      check_eq("ign_mosi", frame_mosi, 8'h12);
      check_eq("ign_rx", rx_data, 8'h81);
      repeat (20) @(posedge clk);
      check_eq("ign_no_extra_acc", acc_cnt - a0, 1);

      // Asynchronous abort after the 3rd sclk rising edge
      r0 = rxv_cnt; s0 = rise_cnt;
      sl_word = 8'hFF;
      send0(8'h0F);
      wait_rise0(s0 + 3, "abt_rise3");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("abt_cs_n", cs_n, 1);
      check_eq("abt_sclk", sclk, 0);
      check_eq("abt_mosi_oe", mosi_oe, 0);
      check_eq("abt_mosi", mosi, 0);
      check_eq("abt_busy", busy, 0);
      check_eq("abt_rx_data", rx_data, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(posedge clk);
      check_eq("abt_no_rxv", rxv_cnt - r0, 0);

      r0 = rxv_cnt;
      sl_word = 8'hE7;
      send0(8'h5A);
      wait_rxv0(r0 + 1, "abt_next_done");
      check_eq("abt_next_mosi", frame_mosi, 8'h5A);
      check_eq("abt_next_rx", rx_data, 8'hE7);

      // CLK_DIV=1: 0x80 out, miso held high
      r0 = rxv1_cnt; s0 = rise1_cnt;
      @(negedge clk);
      tx_valid1 = 1'b1;
      tx_data1  = 8'h80;
      @(negedge clk);
      tx_valid1 = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (rxv1_cnt != r0) break;
      end
      check_eq("d1_done", rxv1_cnt - r0, 1);
      check_eq("d1_latency", rxv1_n - acc1_n, 17);
      check_eq("d1_rx", rx_data1, 8'hFF);
      check_eq("d1_mosi", frame_mosi1, 8'h80);
      check_eq("d1_sclk_period", rise1_gap, 2);
      check_eq("d1_pulses", rise1_cnt - s0, 8);
      check_eq("d1_cs_n_end", cs_n1, 1);
      check_eq("d1_mosi_oe_end", mosi_oe1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
